// File: rtl/pattern_seq_pkg.sv
// Shared definitions for the multi-stage pattern trigger sequencer.
// State codes double as the O_state status register encoding.
package pattern_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FIRE   = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    // Zero stages still means one; never walk past the last register bank.
    function automatic logic [7:0] clamp_stages(
        input logic [7:0] n,
        input logic [7:0] max_n
    );
        logic [7:0] r;
        r = n;
        if (n == 8'd0) begin
            r = 8'd1;
        end else if (n > max_n) begin
            r = max_n;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_byte_timer.sv
// Saturating valid-byte counter with a loadable limit.
// expired_o flags the byte that brings the count up to the limit.
module seq_byte_timer #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] limit_i,
    input  logic         inc_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] limit_q;
    logic [W:0]   next_cnt;

    assign next_cnt  = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    assign expired_o = inc_i
                     & (limit_q != '0)
                     & (next_cnt >= {1'b0, limit_q});

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            limit_q <= '0;
        end else begin
            if (load_i) begin
                limit_q <= limit_i;
            end
            if (clr_i) begin
                count_q <= '0;
            end else if (inc_i && (count_q != '1)) begin
                count_q <= next_cnt[W-1:0];
            end
        end
    end

endmodule

// File: rtl/pattern_trigger_sequencer.sv
// Chains the USB pattern matcher through several pattern/mask stages,
// flushing and re-arming between stages, and fires one trigger at the end.
module pattern_trigger_sequencer
    import pattern_seq_pkg::*;
#(
    parameter int pSTAGES       = 4,
    parameter int pTIMEOUT_BITS = 16,
    parameter int pSETTLE       = 4,
    localparam int SW = (pSTAGES > 1) ? $clog2(pSTAGES) : 1
) (
    input  logic                     fe_clk,
    input  logic                     reset_n_i,
    input  logic                     I_arm,
    input  logic [7:0]               I_num_stages,
    input  logic [pTIMEOUT_BITS-1:0] I_stage_timeout,
    input  logic                     I_fe_data_valid,
    input  logic                     I_capturing,
    input  logic                     I_match,
    output logic [SW-1:0]            O_stage,
    output logic                     O_matcher_arm,
    output logic                     O_matcher_clear,
    output logic                     O_trigger,
    output logic                     O_busy,
    output logic                     O_timeout,
    output logic [2:0]               O_state
);

    localparam int STW = (pSETTLE > 1) ? $clog2(pSETTLE) : 1;
    localparam logic [STW-1:0] SETTLE_LAST = STW'(pSETTLE - 1);
    localparam logic [7:0] MAX_STAGES = 8'(pSTAGES);

    seq_state_e     state_q, state_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [SW-1:0]  last_q, last_d;
    logic [STW-1:0] settle_q, settle_d;
    logic           tflag_q, tflag_d;
    logic           arm_r_q, cap_r_q;
    logic           arm_q, clr_q, trig_q, busy_q;

    logic arm_rise, cap_fall;
    logic tmr_clr, tmr_load, tmr_inc, tmr_expired;

    assign arm_rise = I_arm & ~arm_r_q;
    assign cap_fall = cap_r_q & ~I_capturing;

    assign tmr_load = (state_q == ST_IDLE) & arm_rise;
    assign tmr_clr  = (state_q == ST_CLEAR);
    assign tmr_inc  = (state_q == ST_WAIT)
                    & I_fe_data_valid
                    & (stage_q != '0);

    seq_byte_timer #(
        .W(pTIMEOUT_BITS)
    ) u_timer (
        .clk_i    (fe_clk),
        .rst_n_i  (reset_n_i),
        .clr_i    (tmr_clr),
        .load_i   (tmr_load),
        .limit_i  (I_stage_timeout),
        .inc_i    (tmr_inc),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        last_d   = last_q;
        settle_d = settle_q;
        tflag_d  = tflag_q;
        // Dropping arm beats every other event, wherever we are.
        if ((state_q != ST_IDLE) && !I_arm) begin
            state_d = ST_IDLE;
            stage_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm_rise) begin
                        state_d = ST_CLEAR;
                        stage_d = '0;
                        tflag_d = 1'b0;
                        last_d  = SW'(clamp_stages(I_num_stages,
                                                   MAX_STAGES) - 8'd1);
                    end
                end
                ST_CLEAR: begin
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cap_fall && (stage_q != '0)) begin
                        stage_d = '0;
                        state_d = ST_CLEAR;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_d = ST_WAIT;
                    end else begin
                        settle_d = settle_q + STW'(1);
                    end
                end
                ST_WAIT: begin
                    if (I_match) begin
                        if (stage_q == last_q) begin
                            state_d = ST_FIRE;
                        end else begin
                            stage_d = stage_q + SW'(1);
                            state_d = ST_CLEAR;
                        end
                    end else if (tmr_expired) begin
                        stage_d = '0;
                        tflag_d = 1'b1;
                        state_d = ST_CLEAR;
                    end else if (cap_fall && (stage_q != '0)) begin
                        stage_d = '0;
                        state_d = ST_CLEAR;
                    end
                end
                ST_FIRE: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    stage_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            stage_q  <= '0;
            last_q   <= '0;
            settle_q <= '0;
            tflag_q  <= 1'b0;
            arm_r_q  <= 1'b0;
            cap_r_q  <= 1'b0;
            arm_q    <= 1'b0;
            clr_q    <= 1'b0;
            trig_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            last_q   <= last_d;
            settle_q <= settle_d;
            tflag_q  <= tflag_d;
            arm_r_q  <= I_arm;
            cap_r_q  <= I_capturing;
            arm_q    <= (state_d == ST_WAIT);
            clr_q    <= (state_d == ST_CLEAR);
            trig_q   <= (state_d == ST_FIRE);
            busy_q   <= (state_d != ST_IDLE) && (state_d != ST_DONE);
        end
    end

    assign O_stage         = stage_q;
    assign O_state         = state_q;
    assign O_timeout       = tflag_q;
    assign O_matcher_arm   = arm_q;
    assign O_matcher_clear = clr_q;
    assign O_trigger       = trig_q;
    assign O_busy          = busy_q;

endmodule

// File: tb/tb_pattern_trigger_sequencer.sv
// Bench for pattern_trigger_sequencer: cycle-by-cycle reference model
// plus directed scenarios with literal expectations.
module tb_pattern_trigger_sequencer;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        arm = 1'b0;
    logic [7:0]  nst = 8'd1;
    logic [15:0] tmo = 16'd0;
    logic        valid = 1'b0;
    logic        cap = 1'b0;
    logic        match = 1'b0;

    logic [1:0]  o_stage;
    logic        o_arm, o_clr, o_trig, o_busy, o_tout;
    logic [2:0]  o_st;

    int total = 0;
    int bad = 0;
    int nprint = 0;
    int trig_cnt = 0;
    int clr_cnt = 0;
    int settle_cnt = 0;

    always #5 clk = ~clk;

    pattern_trigger_sequencer #(
        .pSTAGES(4),
        .pTIMEOUT_BITS(16),
        .pSETTLE(S)
    ) dut (
        .fe_clk         (clk),
        .reset_n_i      (rst_n),
        .I_arm          (arm),
        .I_num_stages   (nst),
        .I_stage_timeout(tmo),
        .I_fe_data_valid(valid),
        .I_capturing    (cap),
        .I_match        (match),
        .O_stage        (o_stage),
        .O_matcher_arm  (o_arm),
        .O_matcher_clear(o_clr),
        .O_trigger      (o_trig),
        .O_busy         (o_busy),
        .O_timeout      (o_tout),
        .O_state        (o_st)
    );

    // Reference model: a running sequence is described by the stage and
    // the number of cycles since its last flush (0 = flush cycle).
    bit m_ok = 0, m_run = 0, m_fire = 0, m_done = 0, m_tflag = 0;
    bit p_arm = 0, p_cap = 0;
    int m_age = 0, m_stage = 0, m_last = 0, m_tmo = 0, m_bytes = 0;

    always @(posedge clk) begin : model
        bit capf;
        int n;
        capf = p_cap && !cap;
        if (!rst_n) begin
            m_run = 0; m_fire = 0; m_done = 0; m_tflag = 0;
            m_age = 0; m_stage = 0; m_bytes = 0;
            p_arm = 0; p_cap = 0;
            m_ok = 1;
        end else begin
            if ((m_run || m_fire || m_done) && !arm) begin
                m_run = 0; m_fire = 0; m_done = 0; m_stage = 0;
            end else if (m_done) begin
                m_done = 1;
            end else if (m_fire) begin
                m_fire = 0; m_done = 1;
            end else if (m_run) begin
                if (m_age == 0) begin
                    m_age = 1; m_bytes = 0;
                end else if (m_age <= S) begin
                    if (capf && m_stage > 0) begin
                        m_stage = 0; m_age = 0;
                    end else begin
                        m_age++;
                    end
                end else begin
                    if (valid && m_stage > 0) m_bytes++;
                    if (match) begin
                        if (m_stage == m_last) begin
                            m_run = 0; m_fire = 1;
                        end else begin
                            m_stage++; m_age = 0;
                        end
                    end else if (m_tmo != 0 && m_stage > 0
                                 && m_bytes >= m_tmo) begin
                        m_stage = 0; m_tflag = 1; m_age = 0;
                    end else if (capf && m_stage > 0) begin
                        m_stage = 0; m_age = 0;
                    end
                end
            end else if (arm && !p_arm) begin
                n = int'(nst);
                if (n == 0) n = 1;
                if (n > 4) n = 4;
                m_last = n - 1;
                m_tmo = int'(tmo);
                m_run = 1; m_age = 0; m_stage = 0; m_tflag = 0;
            end
            p_arm = arm;
            p_cap = cap;
        end
    end

    function automatic int exp_state();
        if (m_fire) return 4;
        if (m_done) return 5;
        if (!m_run) return 0;
        if (m_age == 0) return 1;
        if (m_age <= S) return 2;
        return 3;
    endfunction

    always @(negedge clk) begin : compare
        logic [9:0] a, e;
        if (m_ok) begin
            a = {o_stage, o_arm, o_clr, o_trig, o_busy, o_tout, o_st};
            e = {2'(m_stage), m_run && (m_age > S), m_run && (m_age == 0),
                 m_fire, m_run || m_fire, m_tflag, 3'(exp_state())};
            total++;
            if (a !== e) begin
                bad++;
                if (nprint < 20)
                    $display("FAIL cycle_model t=%0t actual=%b required=%b",
                             $time, a, e);
                nprint++;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (o_trig) trig_cnt++;
        if (o_clr) clr_cnt++;
        if (o_st == 3'd2) settle_cnt++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_st(input int s);
        int k;
        k = 0;
        while (int'(o_st) != s && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("wait_state%0d", s), int'(o_st), s);
    endtask

    task automatic match1();
        match = 1'b1;
        @(negedge clk);
        match = 1'b0;
    endtask

    task automatic start(input int n, input int t);
        nst = 8'(n);
        tmo = 16'(t);
        trig_cnt = 0;
        clr_cnt = 0;
        settle_cnt = 0;
        arm = 1'b1;
        @(negedge clk);
    endtask

    task automatic stop();
        arm = 1'b0;
        cyc(2);
    endtask

    initial begin
        cap = 1'b1;
        cyc(3);
        chk("reset_outs", int'({o_stage, o_arm, o_clr, o_trig,
                                o_busy, o_tout, o_st}), 0);
        rst_n = 1'b1;
        cyc(2);

        // single stage
        start(1, 0);
        chk("t1_clear", o_clr, 1);
        wait_st(3);
        match1();
        chk("t1_trig", o_trig, 1);
        chk("t1_fire", o_st, 4);
        cyc(1);
        chk("t1_done", o_st, 5);
        match1();
        match1();
        cyc(2);
        chk("t1_one_pulse", trig_cnt, 1);
        stop();
        chk("t1_idle", o_st, 0);

        // three stages
        start(3, 0);
        for (int k = 0; k < 3; k++) begin
            wait_st(3);
            chk($sformatf("t2_stage%0d", k), o_stage, k);
            match1();
        end
        chk("t2_trig", o_trig, 1);
        cyc(2);
        chk("t2_clears", clr_cnt, 3);
        chk("t2_settle", settle_cnt, 12);
        chk("t2_pulses", trig_cnt, 1);
        stop();

        // timeout on the fifth byte
        start(2, 5);
        wait_st(3);
        match1();
        wait_st(3);
        chk("t3_stage1", o_stage, 1);
        repeat (5) begin
            valid = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        chk("t3_stage", o_stage, 0);
        chk("t3_tout", o_tout, 1);
        chk("t3_state", o_st, 1);
        wait_st(3);
        chk("t3_notrig", trig_cnt, 0);
        stop();
        chk("t3_sticky", o_tout, 1);

        // match together with the fifth byte
        start(2, 5);
        chk("t4_tout_clr", o_tout, 0);
        wait_st(3);
        match1();
        wait_st(3);
        repeat (4) begin
            valid = 1'b1;
            @(negedge clk);
        end
        match = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        match = 1'b0;
        chk("t4_trig", o_trig, 1);
        chk("t4_tout", o_tout, 0);
        stop();

        // match in settle ignored, then abort in stage 1
        start(3, 0);
        wait_st(3);
        match1();
        wait_st(2);
        match1();
        wait_st(3);
        chk("t5_stage", o_stage, 1);
        arm = 1'b0;
        @(negedge clk);
        chk("t5_idle", o_st, 0);
        chk("t5_arm", o_arm, 0);
        chk("t5_stage0", o_stage, 0);
        chk("t5_notrig", trig_cnt, 0);
        cyc(1);

        // capture end restarts from stage 0
        start(2, 0);
        wait_st(3);
        match1();
        wait_st(3);
        cap = 1'b0;
        @(negedge clk);
        chk("t6_stage", o_stage, 0);
        chk("t6_state", o_st, 1);
        chk("t6_tout", o_tout, 0);
        cap = 1'b1;
        stop();

        // zero stages behaves as one
        start(0, 0);
        wait_st(3);
        match1();
        chk("t7_trig", o_trig, 1);
        stop();

        // nine stages clamp to four
        start(9, 0);
        for (int k = 0; k < 4; k++) begin
            wait_st(3);
            chk($sformatf("t8_stage%0d", k), o_stage, k);
            match1();
        end
        chk("t8_trig", o_trig, 1);
        stop();

        // reset while waiting
        start(2, 0);
        wait_st(3);
        rst_n = 1'b0;
        arm = 1'b0;
        @(negedge clk);
        chk("t9_reset", int'({o_stage, o_arm, o_clr, o_trig,
                              o_busy, o_tout, o_st}), 0);
        rst_n = 1'b1;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
